// File: rtl/vga_pkg.sv
// ============================================================================
// Package : vga_pkg
// Shared types and constants for the VGA digit display path.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SHOW    = 2'd2
    } frame_state_t;

    localparam logic [3:0] OPTIONS_DEFAULT = 4'd10;
    localparam logic [3:0] INSTR_TXT       = 4'd0;

    // 640x480 @ 60 Hz timing, shared with vga_driver
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = 525;

endpackage

`default_nettype wire

// File: rtl/frame_lfsr5.sv
// ============================================================================
// Module : frame_lfsr5
// Free-running 5-bit LFSR plus caption index mapping with repeat avoidance.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module frame_lfsr5 import vga_pkg::*; #(
    parameter logic [3:0] OPTIONS   = OPTIONS_DEFAULT,
    parameter logic [4:0] LFSR_SEED = 5'd3
) (
    input  logic       pixClk,
    input  logic       resetN,
    input  logic [3:0] curSel,
    output logic [3:0] nextSel
);

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;
    logic [3:0] mapped;

    always_comb begin
        lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[1]};
    end

    always_ff @(posedge pixClk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Fold the raw nibble into 1..OPTIONS-1, then step past the current caption
    always_comb begin
        mapped = lfsr_q[3:0];
        if (lfsr_q[3:0] == 4'd0) begin
            mapped = 4'd1;
        end else if (lfsr_q[3:0] >= OPTIONS) begin
            mapped = lfsr_q[3:0] - (OPTIONS - 4'd1);
        end

        nextSel = mapped;
        if (mapped == curSel) begin
            nextSel = (curSel >= (OPTIONS - 4'd1)) ? 4'd1 : curSel + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_frame_ctrl.sv
// ============================================================================
// Module : vga_frame_ctrl
// Commits handshaked digits and fresh captions only at vertical sync start.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_frame_ctrl import vga_pkg::*; #(
    parameter logic [3:0]  OPTIONS     = OPTIONS_DEFAULT,
    parameter logic [7:0]  HOLD_FRAMES = 8'd30,
    parameter logic [11:0] IDLE_FRAMES = 12'd1800,
    parameter logic [4:0]  LFSR_SEED   = 5'd3
) (
    input  logic       pixClk,
    input  logic       resetN,
    input  logic       vSync,
    input  logic [3:0] digitIn,
    input  logic       digitValid,
    output logic       digitReady,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic [3:0] txtSelect,
    output logic       commit,
    output logic       digitErr
);

    frame_state_t state_q, state_d;
    logic [3:0]   pendDigit_q, pendDigit_d;
    logic [3:0]   digit_q, digit_d;
    logic         digitEn_q, digitEn_d;
    logic [3:0]   txtSelect_q, txtSelect_d;
    logic         commit_q, commit_d;
    logic         digitErr_q, digitErr_d;
    logic [7:0]   holdCnt_q, holdCnt_d;
    logic [11:0]  idleCnt_q, idleCnt_d;
    logic         vSync_q;
    logic         fe_q;

    logic         xfer;
    logic         badDigit;
    logic         timeout;
    logic [3:0]   nextSel;

    frame_lfsr5 #(
        .OPTIONS   (OPTIONS),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .pixClk  (pixClk),
        .resetN  (resetN),
        .curSel  (txtSelect_q),
        .nextSel (nextSel)
    );

    assign digitReady = resetN & ((state_q == IDLE) |
                                  ((state_q == SHOW) & (holdCnt_q >= HOLD_FRAMES)));
    assign xfer       = digitValid & digitReady;
    assign badDigit   = (digitIn > 4'd9);
    assign timeout    = (IDLE_FRAMES != 12'd0) &&
                        (({1'b0, idleCnt_q} + 13'd1) == {1'b0, IDLE_FRAMES});

    always_comb begin
        state_d     = state_q;
        pendDigit_d = pendDigit_q;
        digit_d     = digit_q;
        digitEn_d   = digitEn_q;
        txtSelect_d = txtSelect_q;
        holdCnt_d   = holdCnt_q;
        idleCnt_d   = idleCnt_q;
        commit_d    = 1'b0;
        digitErr_d  = xfer & badDigit;

        case (state_q)
            IDLE: begin
                if (xfer && !badDigit) begin
                    pendDigit_d = digitIn;
                    state_d     = PENDING;
                end
            end
            PENDING: begin
                if (fe_q) begin
                    digit_d     = pendDigit_q;
                    digitEn_d   = 1'b1;
                    txtSelect_d = nextSel;
                    holdCnt_d   = 8'd0;
                    idleCnt_d   = 12'd0;
                    commit_d    = 1'b1;
                    state_d     = SHOW;
                end
            end
            SHOW: begin
                // A fresh digit takes precedence over this frame's bookkeeping
                if (xfer && !badDigit) begin
                    pendDigit_d = digitIn;
                    state_d     = PENDING;
                end else if (fe_q) begin
                    holdCnt_d = (holdCnt_q == 8'hFF)   ? holdCnt_q : holdCnt_q + 8'd1;
                    idleCnt_d = (idleCnt_q == 12'hFFF) ? idleCnt_q : idleCnt_q + 12'd1;
                    if (timeout) begin
                        digitEn_d   = 1'b0;
                        txtSelect_d = INSTR_TXT;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixClk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            pendDigit_q <= 4'd0;
            digit_q     <= 4'd0;
            digitEn_q   <= 1'b0;
            txtSelect_q <= INSTR_TXT;
            commit_q    <= 1'b0;
            digitErr_q  <= 1'b0;
            holdCnt_q   <= 8'd0;
            idleCnt_q   <= 12'd0;
            vSync_q     <= 1'b1;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pendDigit_q <= pendDigit_d;
            digit_q     <= digit_d;
            digitEn_q   <= digitEn_d;
            txtSelect_q <= txtSelect_d;
            commit_q    <= commit_d;
            digitErr_q  <= digitErr_d;
            holdCnt_q   <= holdCnt_d;
            idleCnt_q   <= idleCnt_d;
            vSync_q     <= vSync;
            fe_q        <= vSync_q & ~vSync;
        end
    end

    assign digit     = digit_q;
    assign digitEn   = digitEn_q;
    assign txtSelect = txtSelect_q;
    assign commit    = commit_q;
    assign digitErr  = digitErr_q;

endmodule

`default_nettype wire

// File: doc/vga_frame_ctrl.md
# vga_frame_ctrl

Frame-synchronous update controller for the VGA digit display. It sits between the digit source (keypad/MCU interface) and the video generator.

- Accepts new digits over a valid/ready handshake.
- Commits them to the display only at the start of the vertical sync pulse, so the digit and caption never tear mid-frame.
- Picks a fresh caption index from an internal LFSR on every commit.
- Enforces a minimum display time per digit.
- Reverts to the instruction caption after a period of inactivity.

## Interface
Parameters:
- OPTIONS, 4'd10: number of caption strings; index 0 is reserved for instructions.
- HOLD_FRAMES, 8'd30: minimum frames a committed digit stays displayed before the next one is accepted.
- IDLE_FRAMES, 12'd1800: frames without a new commit before reverting to instructions; 0 disables the timeout.
- LFSR_SEED, 5'd3: LFSR reset value; must be non-zero.

Ports:
- pixClk  in  1: pixel clock (25.175 MHz); the only clock.
- resetN  in  1: reset, asynchronous, active-low.
- vSync  in  1: active-low vertical sync from vga_driver, same clock domain.
- digitIn  in  4: candidate digit.
- digitValid  in  1: digitIn is valid.
- digitReady  out  1: controller can accept a digit.
- digit  out  4: committed digit to video_gen.
- digitEn  out  1: a digit is being displayed.
- txtSelect  out  4: caption index to video_gen.
- commit  out  1: one-cycle pulse when digit/txtSelect update.
- digitErr  out  1: one-cycle pulse when digitIn > 9 is transferred.

## Operation
States:
- IDLE: instructions shown; digitEn=0, txtSelect=0.
- PENDING: digit accepted, waiting for a frame edge.
- SHOW: digit displayed.

Frame edge (fe) and handshake:
- fe is registered falling-edge detect on vSync: vSyncQ high and vSync low.
- Transfer happens on digitValid & digitReady at a rising pixClk.
- digitReady = resetN & (IDLE | (SHOW & holdCnt >= HOLD_FRAMES)).
- digitReady is 0 in PENDING.

On transfer:
- Digits 0–9: store in pendDigit and go to PENDING.
- Digits 10–15: consumed but discarded. Pulse digitErr in the next cycle; state unchanged.

PENDING with fe (commit):
- digit <= pendDigit, digitEn <= 1, txtSelect <= new index.
- holdCnt <= 0, idleCnt <= 0, commit pulses, go to SHOW.

SHOW with fe:
- holdCnt increments, saturating at 255.
- idleCnt increments, saturating at 4095.
- If IDLE_FRAMES != 0 and idleCnt+1 == IDLE_FRAMES: go to IDLE, digitEn <= 0, txtSelect <= 0, digit keeps its value, no commit pulse.

Caption index:
- 5-bit LFSR free-runs every pixClk: q <= {q[3:0], q[4]^q[1]}.
- At commit, take c = q[3:0]:
  - 1..OPTIONS-1 → c.
  - 0 → 1.
  - ≥ OPTIONS → c-(OPTIONS-1).
- If the result equals the current txtSelect, use (txtSelect mod (OPTIONS-1))+1 instead.
- The result is never 0 and never ≥ OPTIONS.

Boundary conditions:
- Transfer and fe in the same cycle while in SHOW: enter PENDING, no commit on this fe, and the timeout for this fe is suppressed.
- fe in the same cycle as a transfer from IDLE: same rule, commit waits for the next fe.
- Saturated counters remain saturated.
- resetN low mid-operation discards any pending digit immediately.

## Timing
Reset values:
- digit=0, digitEn=0, txtSelect=0, commit=0, digitErr=0, digitReady=0 while resetN low.
- state=IDLE, counters=0, q=LFSR_SEED, vSyncQ=1.

Latency:
- vSync sampled low at edge N (high at N-1) → outputs change and commit=1 after edge N+1.
- Worst-case transfer-to-display is one frame (~16.7 ms at 60 Hz) plus 1 cycle.
- digitErr is asserted for exactly the cycle after the offending transfer.
- digitReady falls the cycle after a transfer (combinational from state).

## Structure
- Shared package vga_pkg holds:
  - state enum typedef {IDLE, PENDING, SHOW}.
  - Caption count OPTIONS_DEFAULT.
  - INSTR_TXT = 4'd0.
  - VGA 640x480 timing constants, shared with vga_driver.
- One sub-module frame_lfsr5 holds the free-running 5-bit LFSR and the index mapping/repeat-avoid logic. Its inputs are the current txtSelect and OPTIONS; its output is the next index.

## Test plan
1. Reset, release: digitReady=1, digitEn=0, txtSelect=0. Send digit 7 mid-frame:
   - digitReady drops next cycle.
   - At the next vSync fall+1: digit=7, digitEn=1, commit=1 for one cycle, txtSelect in 1..9.
2. Hold-time check with HOLD_FRAMES=2:
   - After the commit, digitReady stays 0 until 2 frame edges have passed.
   - Offering digit 3 earlier is not accepted.
   - After the 2nd fe, it is accepted and committed at the 3rd fe.
3. Send digitIn=12:
   - digitErr pulses once.
   - State, digit and txtSelect are unchanged.
   - digitReady stays 1.
4. Timeout with IDLE_FRAMES=5 after a commit of 4 and no further input:
   - At the 5th fe: digitEn=0, txtSelect=0, no commit pulse, digitReady=1.
5. Transfer asserted exactly in the fe cycle during SHOW:
   - No commit on that fe, no timeout on that fe.
   - Commit occurs on the following fe.
6. 1000 commits with random digits:
   - txtSelect never 0, never ≥10, never equal to the previous txtSelect.
   - Pull resetN low mid-PENDING: outputs return to reset values asynchronously, and the pending digit is never displayed.
